skid_pipe: RTL and testbench

Valid/hold pipeline stage that registers the backward hold path, complementing the bubble-collapsing `pipe` stage, which registers the forward path but passes `q_hold` combinationally to `di_hold`. `skid_pipe` absorbs one extra word in a skid register so that `di_hold` is a flop output. This breaks long hold-propagation chains in deep streaming datapaths. With `FWD_REG=1` it is a full register slice: both directions are registered and throughput is one word per cycle.

---
 rtl/skid_pipe_pkg.sv | 30 +++
 rtl/skid_pipe.sv | 139 +++++++++++++
 tb/tb_skid_pipe.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/skid_pipe_pkg.sv
// ============================================================================
// Module      : skid_pipe_pkg
// Description : Shared state encoding and occupancy constants for skid_pipe.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package skid_pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

    localparam logic [1:0] C_OCC_EMPTY = 2'd0;
    localparam logic [1:0] C_OCC_ONE   = 2'd1;
    localparam logic [1:0] C_OCC_TWO   = 2'd2;

    function automatic logic [1:0] occ_of(input skid_state_t st);
        case (st)
            BUSY:    occ_of = C_OCC_ONE;
            FULL:    occ_of = C_OCC_TWO;
            default: occ_of = C_OCC_EMPTY;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/skid_pipe.sv
// ============================================================================
// Module      : skid_pipe
// Description : Valid/hold pipeline stage with a registered backward hold path
//               and an optional registered forward path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module skid_pipe
    import skid_pipe_pkg::*;
#(
    parameter int DW      = 8,
    parameter bit FWD_REG = 1'b1
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          di_valid,
    input  logic [DW-1:0] di,
    output logic          di_hold,
    output logic          q_valid,
    output logic [DW-1:0] q,
    input  logic          q_hold,
    output logic [1:0]    count
);

    generate
        if (FWD_REG) begin : g_fwd_reg
            skid_state_t   state_q, state_d;
            logic          q_valid_q;
            logic          di_hold_q;
            logic [DW-1:0] m_q, m_d;
            logic [DW-1:0] s_q, s_d;
            logic          w_in;
            logic          w_out;

            always_comb begin
                w_in    = di_valid & ~di_hold_q;
                w_out   = q_valid_q & ~q_hold;
                state_d = state_q;
                m_d     = m_q;
                s_d     = s_q;
                case (state_q)
                    EMPTY: begin
                        if (w_in) begin
                            state_d = BUSY;
                            m_d     = di;
                        end
                    end
                    BUSY: begin
                        if (w_in && w_out) begin
                            m_d = di;
                        end else if (w_in) begin
                            state_d = FULL;
                            s_d     = di;
                        end else if (w_out) begin
                            state_d = EMPTY;
                        end
                    end
                    FULL: begin
                        // The skid word moves up; no input is taken this cycle.
                        if (w_out) begin
                            state_d = BUSY;
                            m_d     = s_q;
                        end
                    end
                    default: state_d = EMPTY;
                endcase
            end

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    state_q   <= EMPTY;
                    q_valid_q <= 1'b0;
                    di_hold_q <= 1'b0;
                end else begin
                    state_q   <= state_d;
                    q_valid_q <= (state_d != EMPTY);
                    di_hold_q <= (state_d == FULL);
                end
            end

            always_ff @(posedge clk) begin
                m_q <= m_d;
                s_q <= s_d;
            end

            assign q_valid = q_valid_q;
            assign q       = m_q;
            assign di_hold = di_hold_q;
            assign count   = occ_of(state_q);
        end else begin : g_fwd_comb
            skid_state_t   state_q, state_d;
            logic          di_hold_q;
            logic [DW-1:0] s_q, s_d;

            always_comb begin
                state_d = state_q;
                s_d     = s_q;
                case (state_q)
                    EMPTY: begin
                        // Word is presented combinationally; capture it if blocked.
                        if (di_valid && q_hold) begin
                            state_d = FULL;
                            s_d     = di;
                        end
                    end
                    FULL: begin
                        if (!q_hold) begin
                            state_d = EMPTY;
                        end
                    end
                    default: state_d = EMPTY;
                endcase
            end

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    state_q   <= EMPTY;
                    di_hold_q <= 1'b0;
                end else begin
                    state_q   <= state_d;
                    di_hold_q <= (state_d == FULL);
                end
            end

            always_ff @(posedge clk) begin
                s_q <= s_d;
            end

            assign q_valid = (state_q == FULL) || di_valid;
            assign q       = (state_q == FULL) ? s_q : di;
            assign di_hold = di_hold_q;
            assign count   = (state_q == FULL) ? C_OCC_ONE : C_OCC_EMPTY;
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_skid_pipe.sv
// ============================================================================
// Module      : tb_skid_pipe
// Description : Self-checking bench for skid_pipe in both FWD_REG modes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_skid_pipe;

    localparam int DW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          resetn;
    logic          dv1, dh1, qv1, qh1;
    logic [DW-1:0] d1, q1;
    logic [1:0]    c1;
    logic          dv0, dh0, qv0, qh0;
    logic [DW-1:0] d0, q0;
    logic [1:0]    c0;

    skid_pipe #(.DW(DW), .FWD_REG(1'b1)) dut1 (
        .clk(clk), .resetn(resetn), .di_valid(dv1), .di(d1), .di_hold(dh1),
        .q_valid(qv1), .q(q1), .q_hold(qh1), .count(c1)
    );

    skid_pipe #(.DW(DW), .FWD_REG(1'b0)) dut0 (
        .clk(clk), .resetn(resetn), .di_valid(dv0), .di(d0), .di_hold(dh0),
        .q_valid(qv0), .q(q0), .q_hold(qh0), .count(c0)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        bit         mode;
        bit         dv;
        logic [7:0] d;
        bit         qh;
        bit         eqv;
        logic [7:0] eq;
        bit         edh;
        logic [1:0] ecnt;
    } vec_t;

    vec_t tbl[$];

    // Queues hold buffered words in acceptance order.
    logic [DW-1:0] mq1[$];
    logic [DW-1:0] mq0[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        dv1 = 1'b0; d1 = '0; qh1 = 1'b0;
        dv0 = 1'b0; d0 = '0; qh0 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        mq1.delete();
        mq0.delete();
    endtask

    initial begin
        do_reset();
        #1;
        chk("reset_qv1", qv1, 1'b0);
        chk("reset_dh1", dh1, 1'b0);
        chk("reset_cnt1", c1, 2'd0);
        chk("reset_dh0", dh0, 1'b0);
        chk("reset_cnt0", c0, 2'd0);
        tick();

        // Fill sequence (registered) then bypass/capture sequence (combinational).
        tbl.push_back('{1'b1, 1'b1, 8'hA1, 1'b1, 1'b0, 8'h00, 1'b0, 2'd0});
        tbl.push_back('{1'b1, 1'b1, 8'hA2, 1'b1, 1'b1, 8'hA1, 1'b0, 2'd1});
        tbl.push_back('{1'b1, 1'b1, 8'hA3, 1'b1, 1'b1, 8'hA1, 1'b1, 2'd2});
        tbl.push_back('{1'b1, 1'b1, 8'hA3, 1'b0, 1'b1, 8'hA1, 1'b1, 2'd2});
        tbl.push_back('{1'b1, 1'b1, 8'hA3, 1'b0, 1'b1, 8'hA2, 1'b0, 2'd1});
        tbl.push_back('{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'hA3, 1'b0, 2'd1});
        tbl.push_back('{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 2'd0});
        tbl.push_back('{1'b0, 1'b1, 8'h55, 1'b0, 1'b1, 8'h55, 1'b0, 2'd0});
        tbl.push_back('{1'b0, 1'b1, 8'h55, 1'b1, 1'b1, 8'h55, 1'b0, 2'd0});
        tbl.push_back('{1'b0, 1'b1, 8'h66, 1'b1, 1'b1, 8'h55, 1'b1, 2'd1});
        tbl.push_back('{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h55, 1'b1, 2'd1});
        tbl.push_back('{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 2'd0});
        tbl.push_back('{1'b0, 1'b1, 8'h66, 1'b0, 1'b1, 8'h66, 1'b0, 2'd0});

        foreach (tbl[i]) begin
            if (tbl[i].mode) begin
                dv1 = tbl[i].dv; d1 = tbl[i].d; qh1 = tbl[i].qh; dv0 = 1'b0;
            end else begin
                dv0 = tbl[i].dv; d0 = tbl[i].d; qh0 = tbl[i].qh; dv1 = 1'b0;
            end
            #1;
            if (tbl[i].mode) begin
                chk($sformatf("tbl%0d_qv", i), qv1, tbl[i].eqv);
                chk($sformatf("tbl%0d_dh", i), dh1, tbl[i].edh);
                chk($sformatf("tbl%0d_cnt", i), c1, tbl[i].ecnt);
                if (tbl[i].eqv) chk($sformatf("tbl%0d_q", i), q1, tbl[i].eq);
            end else begin
                chk($sformatf("tbl%0d_qv", i), qv0, tbl[i].eqv);
                chk($sformatf("tbl%0d_dh", i), dh0, tbl[i].edh);
                chk($sformatf("tbl%0d_cnt", i), c0, tbl[i].ecnt);
                if (tbl[i].eqv) chk($sformatf("tbl%0d_q", i), q0, tbl[i].eq);
            end
            tick();
        end
        dv0 = 1'b0; qh0 = 1'b0;

        // Back-to-back stream through the registered stage.
        do_reset();
        for (int i = 1; i <= 16; i++) begin
            dv1 = 1'b1; d1 = 8'(i); qh1 = 1'b0;
            #1;
            if (i > 1) begin
                chk($sformatf("stream%0d_qv", i), qv1, 1'b1);
                chk($sformatf("stream%0d_q", i), q1, 32'(i - 1));
                chk($sformatf("stream%0d_dh", i), dh1, 1'b0);
                chk($sformatf("stream%0d_cnt", i), c1, 2'd1);
            end
            tick();
        end
        dv1 = 1'b0;
        #1;
        chk("stream_last_q", q1, 32'h10);

        // Asynchronous reset while FULL, then first word after release.
        do_reset();
        dv1 = 1'b1; d1 = 8'hA1; qh1 = 1'b1;
        tick();
        d1 = 8'hA2;
        tick();
        dv1 = 1'b0;
        #1;
        chk("prefill_cnt", c1, 2'd2);
        chk("prefill_dh", dh1, 1'b1);
        #2;
        resetn = 1'b0;
        #1;
        chk("async_rst_qv", qv1, 1'b0);
        chk("async_rst_dh", dh1, 1'b0);
        chk("async_rst_cnt", c1, 2'd0);
        tick();
        resetn = 1'b1;
        qh1 = 1'b0;
        #1;
        chk("post_rst_qv", qv1, 1'b0);
        dv1 = 1'b1; d1 = 8'h77;
        tick();
        dv1 = 1'b0;
        #1;
        chk("post_rst_first_qv", qv1, 1'b1);
        chk("post_rst_first_q", q1, 32'h77);
        chk("post_rst_first_cnt", c1, 2'd1);

        // Random traffic against queue models.
        do_reset();
        for (int cyc = 0; cyc < 10000; cyc++) begin
            logic          e_qv1, e_dh1, e_qv0, e_dh0;
            logic [1:0]    e_c1, e_c0;
            logic [DW-1:0] e_q0;
            logic          acc1, con1;

            dv1 = 1'($urandom_range(0, 1)); d1 = 8'($urandom); qh1 = 1'($urandom_range(0, 1));
            dv0 = 1'($urandom_range(0, 1)); d0 = 8'($urandom); qh0 = 1'($urandom_range(0, 1));
            #1;
            e_qv1 = (mq1.size() > 0);
            e_dh1 = (mq1.size() == 2);
            e_c1  = 2'(mq1.size());
            chk("rnd1_qv", qv1, e_qv1);
            chk("rnd1_dh", dh1, e_dh1);
            chk("rnd1_cnt", c1, e_c1);
            if (e_qv1) chk("rnd1_q", q1, mq1[0]);

            if (mq0.size() > 0) begin
                e_qv0 = 1'b1; e_q0 = mq0[0]; e_dh0 = 1'b1; e_c0 = 2'd1;
            end else begin
                e_qv0 = dv0;  e_q0 = d0;     e_dh0 = 1'b0; e_c0 = 2'd0;
            end
            chk("rnd0_qv", qv0, e_qv0);
            chk("rnd0_dh", dh0, e_dh0);
            chk("rnd0_cnt", c0, e_c0);
            if (e_qv0) chk("rnd0_q", q0, e_q0);

            // di_hold must not follow q_hold within a cycle.
            qh1 = ~qh1; qh0 = ~qh0;
            #1;
            chk("rnd1_hold_path", dh1, e_dh1);
            chk("rnd0_hold_path", dh0, e_dh0);
            qh1 = ~qh1; qh0 = ~qh0;
            #1;

            acc1 = dv1 && (mq1.size() < 2);
            con1 = (mq1.size() > 0) && !qh1;
            if (con1) void'(mq1.pop_front());
            if (acc1) mq1.push_back(d1);

            if (mq0.size() > 0) begin
                if (!qh0) void'(mq0.pop_front());
            end else if (dv0 && qh0) begin
                mq0.push_back(d0);
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
